// File: rtl/common.sv
// Shared cbus types used by the core-side bus master and everything that
// multiplexes onto it.
package common;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [7:0]  len;     // beats - 1
    burst_t      burst;
    logic [31:0] data;
    logic [3:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int CBUS_NREQ_DEFAULT = 2;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Round-robin picker: first set bit of valid, scanning ptr, ptr+1, ...
// modulo N. Purely combinational; also used by the cache MSHR arbiter.
module rr_pick #(
  parameter  int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);

  // Walk the ring backwards so the candidate closest to ptr wins last.
  always_comb begin
    int j;
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (valid[j]) begin
        found = 1'b1;
        index = W'(j);
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing the core-side cbus master port between NREQ
// requesters. Grant is registered (one-cycle latency), held for the whole
// transaction including every burst beat, and dropped on ready&&last.
module cbus_arbiter
  import common::*;
#(
  parameter  int NREQ = CBUS_NREQ_DEFAULT,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  cbus_req_t  [NREQ-1:0]  ireqs,
  output cbus_resp_t [NREQ-1:0]  iresps,
  output cbus_req_t              oreq,
  input  cbus_resp_t             oresp
);

  arb_state_t       state;
  logic [IDXW-1:0]  sel;
  logic [IDXW-1:0]  rr_ptr;
  logic [NREQ-1:0]  vld;
  logic             found;
  logic [IDXW-1:0]  pick;
  logic             done;
  logic [IDXW-1:0]  sel_next;

  for (genvar i = 0; i < NREQ; i++) begin : g_vld
    assign vld[i] = ireqs[i].valid;
  end

  rr_pick #(.N(NREQ)) u_pick (
    .valid (vld),
    .ptr   (rr_ptr),
    .found (found),
    .index (pick)
  );

  assign done = oresp.ready && oresp.last;

  // Explicit wrap so non-power-of-two NREQ never lands on an unused index.
  assign sel_next = (sel == IDXW'(NREQ - 1)) ? '0 : sel + 1'b1;

  // Grant FSM: latch the picked requester in IDLE, release on the last beat.
  // The mandatory IDLE cycle after completion keeps the mux select registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            rr_ptr <= sel_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Granted requester drives the bus straight through, so data/strobe can
  // change beat by beat; a dropped valid is forwarded as-is.
  assign oreq = (state == BUSY) ? ireqs[sel] : '0;

  // Only the granted requester ever sees the bus response.
  for (genvar i = 0; i < NREQ; i++) begin : g_resp
    assign iresps[i] = (state == BUSY && sel == IDXW'(i)) ? oresp : '0;
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: a 2-requester instance driven from a vector table
// and hand sequences, and a 3-requester instance for wrap and random checks.
module tb_cbus_arbiter;
  import common::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NREQ=2 instance
  logic                rst_a;
  cbus_req_t  [1:0]    ireqs_a;
  cbus_resp_t [1:0]    iresps_a;
  cbus_req_t           oreq_a;
  cbus_resp_t          oresp_a;

  // NREQ=3 instance
  logic                rst_b;
  cbus_req_t  [2:0]    ireqs_b;
  cbus_resp_t [2:0]    iresps_b;
  cbus_req_t           oreq_b;
  cbus_resp_t          oresp_b;

  cbus_arbiter #(.NREQ(2)) dut_a (
    .clk(clk), .reset(rst_a), .ireqs(ireqs_a), .iresps(iresps_a),
    .oreq(oreq_a), .oresp(oresp_a));

  cbus_arbiter #(.NREQ(3)) dut_b (
    .clk(clk), .reset(rst_b), .ireqs(ireqs_b), .iresps(iresps_b),
    .oreq(oreq_b), .oresp(oresp_b));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  vld;
    logic        rdy;
    logic        lst;
    logic [31:0] rdata;
    logic [31:0] wdata;
    int          gnt;     // requester expected on the bus, -1 = none
  } vec_t;

  vec_t tbl[15];

  function automatic cbus_req_t mkreq(input int id, input logic v, input logic [31:0] wd);
    cbus_req_t r;
    r.valid  = v;
    r.write  = (id != 0);
    r.addr   = (id == 0) ? 32'h8000_0000 : (id == 1) ? 32'h4000_0010 : 32'h2000_0020;
    r.len    = (id == 0) ? 8'd0 : 8'd3;
    r.burst  = BURST_INCR;
    r.data   = wd;
    r.strobe = 4'hF;
    return r;
  endfunction

  task automatic chk_req(input string nm, input cbus_req_t act, input cbus_req_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s oreq: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_resp(input string nm, input int i, input cbus_resp_t act, input cbus_resp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s iresps[%0d]: got %h expected %h", nm, i, act, exp);
    end
  endtask

  task automatic drive_a(input logic [1:0] v, input logic r, input logic l,
                         input logic [31:0] rd, input logic [31:0] wd);
    for (int i = 0; i < 2; i++) ireqs_a[i] = mkreq(i, v[i], wd);
    oresp_a.ready = r;
    oresp_a.last  = l;
    oresp_a.data  = rd;
  endtask

  task automatic drive_b(input logic [2:0] v, input logic r, input logic l);
    for (int i = 0; i < 3; i++) ireqs_b[i] = mkreq(i, v[i], 32'h0);
    oresp_b.ready = r;
    oresp_b.last  = l;
    oresp_b.data  = 32'h1234_5678;
  endtask

  // Expected outputs: the owner sees the bus both ways, everyone else zero.
  task automatic check_a(input string nm, input int g);
    cbus_req_t  er;
    cbus_resp_t ep;
    er = (g >= 0) ? ireqs_a[g] : '0;
    chk_req(nm, oreq_a, er);
    for (int i = 0; i < 2; i++) begin
      ep = (i == g) ? oresp_a : '0;
      chk_resp(nm, i, iresps_a[i], ep);
    end
  endtask

  task automatic check_b(input string nm, input int g);
    cbus_req_t  er;
    cbus_resp_t ep;
    er = (g >= 0) ? ireqs_b[g] : '0;
    chk_req(nm, oreq_b, er);
    for (int i = 0; i < 3; i++) begin
      ep = (i == g) ? oresp_b : '0;
      chk_resp(nm, i, iresps_b[i], ep);
    end
  endtask

  // Reference model for the random phase: who owns the bus, and where the
  // round-robin search starts next time the bus is free.
  int m_own;
  int m_ptr;

  task automatic model_advance();
    int j;
    if (m_own < 0) begin
      for (int k = 0; k < 3; k++) begin
        j = (m_ptr + k) % 3;
        if (ireqs_b[j].valid) begin
          m_own = j;
          break;
        end
      end
    end else if (oresp_b.ready && oresp_b.last) begin
      m_ptr = (m_own + 1) % 3;
      m_own = -1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    // single read (rows 0-3), 4-beat write burst (4-10), dropped valid (11-14)
    tbl[0]  = '{2'b01, 1'b0, 1'b0, 32'h0,         32'h0,  -1};
    tbl[1]  = '{2'b01, 1'b0, 1'b0, 32'h0,         32'h0,   0};
    tbl[2]  = '{2'b01, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0,   0};
    tbl[3]  = '{2'b00, 1'b0, 1'b0, 32'h0,         32'h0,  -1};
    tbl[4]  = '{2'b10, 1'b0, 1'b0, 32'h0,         32'hA0, -1};
    tbl[5]  = '{2'b10, 1'b1, 1'b0, 32'h0,         32'hA1,  1};
    tbl[6]  = '{2'b10, 1'b1, 1'b0, 32'h0,         32'hA2,  1};
    tbl[7]  = '{2'b10, 1'b1, 1'b0, 32'h0,         32'hA3,  1};
    tbl[8]  = '{2'b10, 1'b1, 1'b1, 32'h0,         32'hA4,  1};
    tbl[9]  = '{2'b00, 1'b0, 1'b0, 32'h0,         32'h0,  -1};
    tbl[10] = '{2'b10, 1'b0, 1'b0, 32'h0,         32'h0,  -1};
    tbl[11] = '{2'b00, 1'b0, 1'b0, 32'h0,         32'h0,   1};
    tbl[12] = '{2'b00, 1'b1, 1'b0, 32'h0,         32'h0,   1};
    tbl[13] = '{2'b10, 1'b1, 1'b1, 32'h5,         32'h0,   1};
    tbl[14] = '{2'b00, 1'b0, 1'b0, 32'h0,         32'h0,  -1};

    rst_a = 1'b0;
    rst_b = 1'b0;
    drive_a(2'b11, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0);
    drive_b(3'b111, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    check_a("reset_a", -1);
    check_b("reset_b", -1);
    @(negedge clk);
    rst_a = 1'b1;

    // ---- table-driven: single read, burst write, protocol violation ----
    for (int k = 0; k < 15; k++) begin
      drive_a(tbl[k].vld, tbl[k].rdy, tbl[k].lst, tbl[k].rdata, tbl[k].wdata);
      #1;
      check_a($sformatf("tbl%0d", k), tbl[k].gnt);
      @(negedge clk);
    end

    // ---- contention: grants 0,1,0,1 with one idle cycle between ----
    for (int c = 0; c < 8; c++) begin
      drive_a(2'b11, 1'b1, 1'b1, 32'hC0 + 32'(c), 32'h0);
      #1;
      check_a($sformatf("contend%0d", c), (c % 2 == 0) ? -1 : ((c - 1) / 2) % 2);
      @(negedge clk);
    end

    // ---- arrival during BUSY: req1 shows up at beat 3 of an 8-beat burst ----
    for (int c = 0; c <= 11; c++) begin
      logic [1:0] v;
      int g;
      v = (c == 0) ? 2'b01 : (c < 3) ? 2'b01 : (c <= 8) ? 2'b11 : (c <= 10) ? 2'b10 : 2'b00;
      g = (c == 0) ? -1 : (c <= 8) ? 0 : (c == 9) ? -1 : (c == 10) ? 1 : -1;
      drive_a(v, (c >= 1 && c <= 8) || c == 10, c == 8 || c == 10, 32'hB0 + 32'(c), 32'(c));
      #1;
      check_a($sformatf("arrive%0d", c), g);
      @(negedge clk);
    end

    // ---- reset mid-burst: req1 owns the bus, reset at beat 2 ----
    drive_a(2'b10, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; check_a("rstburst_idle", -1);
    @(negedge clk);
    drive_a(2'b10, 1'b1, 1'b0, 32'h0, 32'h1);
    #1; check_a("rstburst_beat1", 1);
    @(negedge clk);
    drive_a(2'b10, 1'b1, 1'b0, 32'h0, 32'h2);
    #1; check_a("rstburst_beat2", 1);
    #1 rst_a = 1'b0;
    #1; check_a("rstburst_async", -1);
    @(negedge clk);
    rst_a = 1'b1;
    drive_a(2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; check_a("rstburst_after_idle", -1);
    @(negedge clk);
    drive_a(2'b11, 1'b1, 1'b1, 32'h77, 32'h0);
    #1; check_a("rstburst_regrant0", 0);
    @(negedge clk);
    drive_a(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; check_a("rstburst_done", -1);
    @(negedge clk);

    // ---- NREQ=3: move rr_ptr to 1, then 0 and 2 contend -> 2 then 0 ----
    rst_b = 1'b1;
    begin
      logic [2:0] vb[6];
      logic       rl[6];
      int         gb[6];
      vb = '{3'b001, 3'b001, 3'b101, 3'b101, 3'b001, 3'b001};
      rl = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
      gb = '{-1,     0,      -1,     2,      -1,     0};
      for (int c = 0; c < 6; c++) begin
        drive_b(vb[c], rl[c], rl[c]);
        #1;
        check_b($sformatf("n3_%0d", c), gb[c]);
        @(negedge clk);
      end
    end

    // ---- random stimulus on NREQ=3 against the reference model ----
    rst_b = 1'b0;
    #1;
    m_own = -1;
    m_ptr = 0;
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      rst_b = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < 3; i++)
        ireqs_b[i] = mkreq(i, ($urandom_range(0, 2) != 0), $urandom);
      oresp_b.ready = $urandom_range(0, 1) == 1;
      oresp_b.last  = $urandom_range(0, 2) == 0;
      oresp_b.data  = $urandom;
      #1;
      if (!rst_b) begin
        m_own = -1;
        m_ptr = 0;
      end
      check_b($sformatf("rand%0d", c), m_own);
      if (rst_b) model_advance();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
